stream_mux_n: RTL and testbench
===============================

# stream_mux_n

Parametrised N-channel, registered stream multiplexer with valid/ready handshakes on every channel and two selection modes: externally selected (fixed) and round-robin arbitration. It is the next generation of the team's 2:1 combinational mux. It sits between multiple producer streams and a single consumer. It adds back-pressure, one pipeline register and fair sharing.

## Interface

Parameters:

- N_CH, 4, number of input channels (≥2)
- WIDTH, 8, data width per channel (≥1)
- SEL_W, $clog2(N_CH), derived localparam; not overridable

Ports:

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- mode  in  1  0 = MODE_FIXED, 1 = MODE_RR
- sel  in  SEL_W  channel index used in MODE_FIXED
- in_valid  in  N_CH  per-channel valid
- in_data  in  N_CH*WIDTH  packed; channel i at [i*WIDTH +: WIDTH]
- in_ready  out  N_CH  per-channel ready (combinational)
- out_valid  out  1  output register holds a beat
- out_data  out  WIDTH  registered data
- out_ch  out  SEL_W  source channel of the held beat
- out_ready  in  1  consumer ready

## Operation

- **Transfer rules:**
  - A beat transfers on a channel when valid && ready are both high at a rising edge.
  - The output transfers when out_valid && out_ready.
- **Load enable:**
  - load_en = !out_valid || out_ready.
  - The output register loads only when load_en is high and a grant exists.
- **Ready generation:** in_ready[i] = load_en && grant_vld && (grant == i). At most one in_ready bit is high per cycle.
- **MODE_FIXED:**
  - grant = sel; grant_vld = in_valid[sel] && (sel < N_CH).
  - If sel ≥ N_CH there is no grant and all in_ready are 0.
- **MODE_RR:**
  - grant is the first channel with in_valid set, searching upward from rr_ptr+1 with wrap-around modulo N_CH.
  - rr_ptr updates to the granted index only on an actual input transfer.
  - rr_ptr is unchanged in MODE_FIXED.
- **On load:**
  - out_data ← in_data[grant]
  - out_ch ← grant
  - out_valid ← 1
- **On output transfer with no new load:** out_valid ← 0. out_data and out_ch hold their last value.
- **Stalls:** while out_valid && !out_ready, out_data and out_ch are held stable and all in_ready are 0.
- **Mode/sel changes:** a change of mode or sel affects only the grant for the current cycle. A beat already held in the output register is never altered.
- **Reset (including mid-operation):** any held beat is discarded. On the first clock edge with rst_n low:
  - out_valid = 0
  - out_data = 0
  - out_ch = 0
  - rr_ptr = N_CH-1, so channel 0 has first priority after reset
- **Outputs during reset:** in_ready is 0 while rst_n is low.

## Timing

- **Latency:** 1 cycle from input transfer to out_valid high.
- **Throughput:** 1 beat/cycle sustained while out_ready = 1.
- **Simultaneous events:** when an output transfer and a new load occur in the same cycle, out_valid stays 1 and the data is replaced.
- **Combinational paths:**
  - in_ready depends combinationally on out_ready, in_valid, mode and sel.
  - No combinational path from in_* to out_valid, out_data or out_ch.
- **RR fairness:** with all N_CH channels continuously valid and out_ready = 1, each channel is granted exactly once in every N_CH consecutive transfers.

## Structure

- **Package stream_mux_pkg:**
  - typedef enum logic {MODE_FIXED, MODE_RR} mux_mode_e
  - a function computing the wrap-around first-set search, shared with the arbiter
- **Sub-module rr_arbiter:**
  - parameter N_CH
  - inputs: req, ptr
  - outputs: gnt_idx, gnt_vld
  - purely combinational
- **Top module:** handles mode selection, load_en, the output register and rr_ptr.

## Test plan

- **Reset:** drive rst_n = 0 for 2 cycles during an active stream, then release. Required: out_valid = 0, out_data = 0, out_ch = 0, all in_ready = 0 during reset. The first RR grant after release goes to channel 0.
- **Fixed mode:** mode = 0, sel = 2, in_valid = 4'b1111, in_data lanes = {8'hD3, 8'hC2, 8'hB1, 8'hA0} (ch3..ch0), out_ready = 1. Required: only in_ready[2] high; next cycle out_data = 8'hC2, out_ch = 2.
- **Round robin:** mode = 1, in_valid = 4'b1111, out_ready = 1 for 8 cycles. Required: out_ch sequence 0,1,2,3,0,1,2,3 with out_valid continuously high.
- **RR skip:** mode = 1, in_valid = 4'b1010. Required: out_ch alternates 1,3,1,3. Channels 0 and 2 never get in_ready.
- **Back-pressure:** hold out_ready = 0 for 3 cycles with a beat loaded (out_data = 8'h5A). Required: out_data and out_ch stable, all in_ready = 0. When out_ready returns to 1, the next beat loads in the same cycle as the drain.
- **Invalid select:** N_CH = 3, mode = 0, sel = 3, in_valid = 3'b111. Required: no in_ready high, out_valid stays 0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared types and arbitration helper for the N-channel stream mux.
package stream_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

    localparam int MAX_CH = 64;

    // First set request searching upward from ptr+1 with wrap; -1 if none.
    function automatic int rr_first(
        input logic [MAX_CH-1:0] req,
        input int                n,
        input int                ptr
    );
        int res;
        int j;
        res = -1;
        for (int k = MAX_CH; k >= 1; k--) begin
            if (k <= n) begin
                j = ptr + k;
                if (j >= n) j = j - n;
                if (req[j]) res = j;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/stream_mux_n_arb.sv
// Combinational round-robin arbiter for stream_mux_n.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    int first;

    assign first   = rr_first(MAX_CH'(req), N_CH, int'(ptr));
    assign gnt_vld = (first >= 0);
    assign gnt_idx = gnt_vld ? SEL_W'(first) : '0;

endmodule

// File: rtl/stream_mux_n.sv
// Registered N:1 stream mux with fixed-select and round-robin modes.
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    input  logic                  out_ready
);

    logic             load_en;
    logic             grant_vld;
    logic             fixed_vld;
    logic             rr_vld;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] rr_idx;
    logic [SEL_W-1:0] rr_ptr;
    logic [WIDTH-1:0] grant_data;

    rr_arbiter #(
        .N_CH    (N_CH)
    ) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

    always_comb begin
        fixed_vld  = 1'b0;
        grant_data = '0;
        in_ready   = '0;
        // An out-of-range sel matches no channel, so it never grants.
        for (int i = 0; i < N_CH; i++) begin
            if (sel == SEL_W'(i)) fixed_vld = in_valid[i];
        end
        grant     = (mode == MODE_RR) ? rr_idx : sel;
        grant_vld = (mode == MODE_RR) ? rr_vld : fixed_vld;
        load_en   = !out_valid || out_ready;
        for (int i = 0; i < N_CH; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data  = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = rst_n && load_en && grant_vld;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= SEL_W'(N_CH - 1);
        end else if (load_en && grant_vld) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_ch    <= grant;
            if (mode == MODE_RR) rr_ptr <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_n.sv
// Self-checking bench for stream_mux_n against a behavioural model.
module tb_stream_mux_n;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready;

    logic        mode3;
    logic [1:0]  sel3;
    logic [2:0]  valid3;
    logic [23:0] data3;
    logic [2:0]  ready3;
    logic        ovalid3;
    logic [7:0]  odata3;
    logic [1:0]  och3;
    logic        oready3;

    int checks = 0;
    int errors = 0;

    logic       m_vld;
    logic [7:0] m_data;
    int         m_ch;
    int         m_ptr;

    stream_mux_n #(.N_CH(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    stream_mux_n #(.N_CH(3), .WIDTH(8)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode3),
        .sel       (sel3),
        .in_valid  (valid3),
        .in_data   (data3),
        .in_ready  (ready3),
        .out_valid (ovalid3),
        .out_data  (odata3),
        .out_ch    (och3),
        .out_ready (oready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m_grant();
        int c;
        if (mode == 1'b0) begin
            if (in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 1; k <= 4; k++) begin
            c = (m_ptr + k) % 4;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_ready();
        int g;
        g = m_grant();
        if (!rst_n || (m_vld && !out_ready) || g < 0) return 4'b0000;
        return 4'b0001 << g;
    endfunction

    task automatic m_update();
        int g;
        g = m_grant();
        if (!rst_n) begin
            m_vld  = 1'b0;
            m_data = 8'h00;
            m_ch   = 0;
            m_ptr  = 3;
        end else if ((!m_vld || out_ready) && g >= 0) begin
            m_vld  = 1'b1;
            m_data = in_data[g*8 +: 8];
            m_ch   = g;
            if (mode) m_ptr = g;
        end else if (out_ready) begin
            m_vld = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mode      = 1'b1;
        sel       = 2'd0;
        in_valid  = 4'b1111;
        in_data   = 32'hD3C2B1A0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0000 || ready3 !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready got %b/%b want 0", in_ready, ready3);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
            errors++;
            $display("FAIL reset_out got v%b d%h c%0d want 0", out_valid, out_data, out_ch);
        end
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_rr got %b want 0001", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'hA0) begin
            errors++;
            $display("FAIL reset_first_beat got v%b c%0d d%h want 1 0 a0", out_valid, out_ch, out_data);
        end
    endtask

    task automatic test_fixed();
        mode      = 1'b0;
        sel       = 2'd2;
        in_valid  = 4'b1111;
        in_data   = 32'hD3C2B1A0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL fixed_ready got %b want 0100", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hC2 || out_ch !== 2'd2) begin
            errors++;
            $display("FAIL fixed_out got v%b d%h c%0d want 1 c2 2", out_valid, out_data, out_ch);
        end
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        mode      = 1'b1;
        in_valid  = 4'b1111;
        in_data   = 32'h44332211;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (in_ready !== (4'b0001 << (k % 4))) begin
                errors++;
                $display("FAIL rr_ready[%0d] got %b want ch %0d", k, in_ready, k % 4);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || int'(out_ch) != k % 4 ||
                out_data !== 8'(8'h11 * (k % 4 + 1))) begin
                errors++;
                $display("FAIL rr_seq[%0d] got v%b c%0d d%h want ch %0d",
                         k, out_valid, out_ch, out_data, k % 4);
            end
        end
    endtask

    task automatic test_rr_skip();
        logic [1:0] want;
        mode      = 1'b1;
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            want = (k % 2 == 0) ? 2'd1 : 2'd3;
            #1;
            checks++;
            if (in_ready[0] !== 1'b0 || in_ready[2] !== 1'b0) begin
                errors++;
                $display("FAIL skip_ready[%0d] got %b want 0 on ch0/ch2", k, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_ch !== want) begin
                errors++;
                $display("FAIL skip_seq[%0d] got c%0d want %0d", k, out_ch, want);
            end
        end
    endtask

    task automatic test_back_pressure();
        mode      = 1'b0;
        sel       = 2'd0;
        in_valid  = 4'b0001;
        in_data   = 32'h0000005A;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_data   = 32'h00000077;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_ready[%0d] got %b want 0000", k, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h5A || out_ch !== 2'd0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v%b d%h c%0d want 1 5a 0",
                         k, out_valid, out_data, out_ch);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_release got %b want 0001", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h77) begin
            errors++;
            $display("FAIL bp_reload got v%b d%h want 1 77", out_valid, out_data);
        end
    endtask

    task automatic test_random();
        logic [3:0] want;
        for (int k = 0; k < 400; k++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            want = m_ready();
            checks++;
            if (in_ready !== want) begin
                errors++;
                $display("FAIL rand_ready[%0d] got %b want %b", k, in_ready, want);
            end
            tick();
            checks++;
            if (out_valid !== m_vld ||
                (m_vld && (out_data !== m_data || int'(out_ch) != m_ch))) begin
                errors++;
                $display("FAIL rand_out[%0d] got v%b d%h c%0d want v%b d%h c%0d",
                         k, out_valid, out_data, out_ch, m_vld, m_data, m_ch);
            end
        end
    endtask

    task automatic test_invalid_sel();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (ready3 !== 3'b000) begin
                errors++;
                $display("FAIL inv_ready[%0d] got %b want 000", k, ready3);
            end
            tick();
            checks++;
            if (ovalid3 !== 1'b0) begin
                errors++;
                $display("FAIL inv_valid[%0d] got %b want 0", k, ovalid3);
            end
        end
        sel3 = 2'd2;
        #1;
        checks++;
        if (ready3 !== 3'b100) begin
            errors++;
            $display("FAIL n3_sel2_ready got %b want 100", ready3);
        end
        tick();
        checks++;
        if (ovalid3 !== 1'b1 || och3 !== 2'd2 || odata3 !== 8'h33) begin
            errors++;
            $display("FAIL n3_sel2_out got v%b c%0d d%h want 1 2 33", ovalid3, och3, odata3);
        end
        sel3 = 2'd3;
        tick();
        checks++;
        if (ovalid3 !== 1'b0 || ready3 !== 3'b000) begin
            errors++;
            $display("FAIL n3_drain got v%b r%b want 0 000", ovalid3, ready3);
        end
    endtask

    initial begin
        mode3   = 1'b0;
        sel3    = 2'd3;
        valid3  = 3'b111;
        data3   = 24'h332211;
        oready3 = 1'b1;
        m_vld   = 1'b0;
        m_data  = 8'h00;
        m_ch    = 0;
        m_ptr   = 3;
        test_reset();
        test_fixed();
        test_round_robin();
        test_rr_skip();
        test_back_pressure();
        test_random();
        test_invalid_sel();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
